// File: rtl/wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the register-file write port between the writeback stage and the
//   multiply/divide unit. The pipeline has priority. An aging counter forces
//   an MDU grant after MAX_WAIT consecutive losses. The winning write is
//   registered toward the register file.
//
// Ports
//   clk_i, rst_i       clock (rising edge), synchronous active-high reset
//   pipe_*_i           writeback-stage write request (valid/regen/addr/data)
//   pipe_ready_o       pipeline request accepted this cycle (combinational)
//   mdu_*_i            MDU result request (valid/addr/data)
//   mdu_ready_o        MDU request accepted this cycle (combinational)
//   rf_we_o/waddr_o/wdata_o  registered register-file write
//   force_mdu_o        arbiter is in the forced-MDU state
// ----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_valid_i,
    input  logic        pipe_regen_i,
    input  logic [4:0]  pipe_rd_addr_i,
    input  logic [31:0] pipe_rd_i,
    output logic        pipe_ready_o,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_addr_i,
    input  logic [31:0] mdu_rd_i,
    output logic        mdu_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        force_mdu_o
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        NORMAL    = 1'b0,
        FORCE_MDU = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic        pipe_need;
    logic        mdu_need;
    logic        grant_pipe;
    logic        grant_mdu;

    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;

    // Requests targeting x0 (or not writing at all) never occupy the port.
    assign pipe_need = pipe_valid_i & pipe_regen_i & (pipe_rd_addr_i != 5'd0);
    assign mdu_need  = mdu_valid_i & (mdu_rd_addr_i != 5'd0);

    // State register and aging counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= NORMAL;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and aging logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            NORMAL: begin
                if (pipe_need && mdu_need) begin
                    // MDU loses this cycle; the last tolerated loss forces it next.
                    if (wait_cnt_q >= WAIT_LAST) begin
                        state_d    = FORCE_MDU;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            FORCE_MDU: begin
                // Leave after the forced grant, or at once if the MDU dropped valid.
                state_d    = NORMAL;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = NORMAL;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Grant and ready generation.
    always_comb begin
        grant_pipe   = 1'b0;
        grant_mdu    = 1'b0;
        pipe_ready_o = 1'b0;
        mdu_ready_o  = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                NORMAL: begin
                    if (pipe_need) begin
                        grant_pipe   = 1'b1;
                        pipe_ready_o = 1'b1;
                    end else if (pipe_valid_i) begin
                        pipe_ready_o = 1'b1;
                    end
                    if (mdu_need && !pipe_need) begin
                        grant_mdu   = 1'b1;
                        mdu_ready_o = 1'b1;
                    end else if (mdu_valid_i && !mdu_need) begin
                        mdu_ready_o = 1'b1;
                    end
                end
                FORCE_MDU: begin
                    if (mdu_need) begin
                        grant_mdu   = 1'b1;
                        mdu_ready_o = 1'b1;
                    end else if (mdu_valid_i) begin
                        mdu_ready_o = 1'b1;
                    end
                    // A non-writing pipeline request can still retire here.
                    if (pipe_valid_i && !pipe_need) begin
                        pipe_ready_o = 1'b1;
                    end
                end
                default: begin
                    grant_pipe = 1'b0;
                end
            endcase
        end
    end

    // Registered write toward the register file; address/data hold when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= grant_pipe | grant_mdu;
            if (grant_pipe) begin
                rf_waddr_q <= pipe_rd_addr_i;
                rf_wdata_q <= pipe_rd_i;
            end else if (grant_mdu) begin
                rf_waddr_q <= mdu_rd_addr_i;
                rf_wdata_q <= mdu_rd_i;
            end
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign force_mdu_o = (state_q == FORCE_MDU);

endmodule
